// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg7_reader
// Purpose  : Debounces and decodes an asynchronous active-low 7-segment bus
//            into a hex digit with blank/error flags and a VALID/ACK handshake.
//            Define SEG7_READER_OVF_EN to add the sticky OVF drop flag.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] HEX,
  input  logic       EN,
  input  logic       ACK,
  output logic [3:0] DOUT,
  output logic       BLANK,
  output logic       ERR,
  output logic       VALID
`ifdef SEG7_READER_OVF_EN
  ,
  output logic       OVF
`endif
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] C_BLANK  = 7'h7F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [6:0] r_sync1;
  logic [6:0] r_samp;
  logic [6:0] r_prev;
  logic [7:0] r_cnt;
  logic [6:0] r_last;
  logic       r_last_vld;
  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] w_cnt_nxt;
  logic       w_accept;
  logic       w_load;
  logic       w_drop;
  logic       w_ack_taken;
  logic [3:0] w_dec_digit;
  logic       w_dec_blank;
  logic       w_dec_err;

  // Synchronizer plus one-cycle history of the sampled pattern
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= C_BLANK;
      r_samp  <= C_BLANK;
      r_prev  <= C_BLANK;
    end else begin
      r_sync1 <= HEX;
      r_samp  <= r_sync1;
      r_prev  <= r_samp;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!EN)                    w_cnt_nxt = 8'd0;
    else if (r_samp != r_prev)  w_cnt_nxt = 8'd1;
    else if (r_cnt == C_STABLE) w_cnt_nxt = C_STABLE;
    else                        w_cnt_nxt = r_cnt + 8'd1;
  end

  // Fires only on the single edge where the count climbs into saturation
  assign w_accept = EN && (r_samp == r_prev) && (r_cnt == C_STABLE - 8'd1)
                    && (!r_last_vld || (r_samp != r_last));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt      <= 8'd0;
      r_last     <= C_BLANK;
      r_last_vld <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (!EN) begin
        r_last_vld <= 1'b0;
      end else if (w_accept) begin
        r_last     <= r_samp;
        r_last_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_dec_digit = 4'h0;
    w_dec_blank = 1'b0;
    w_dec_err   = 1'b0;
    case (r_samp)
      7'h40: w_dec_digit = 4'h0;
      7'h79: w_dec_digit = 4'h1;
      7'h24: w_dec_digit = 4'h2;
      7'h30: w_dec_digit = 4'h3;
      7'h19: w_dec_digit = 4'h4;
      7'h12: w_dec_digit = 4'h5;
      7'h02: w_dec_digit = 4'h6;
      7'h58: w_dec_digit = 4'h7;
      7'h00: w_dec_digit = 4'h8;
      7'h10: w_dec_digit = 4'h9;
      7'h08: w_dec_digit = 4'hA;
      7'h03: w_dec_digit = 4'hB;
      7'h46: w_dec_digit = 4'hC;
      7'h21: w_dec_digit = 4'hD;
      7'h06: w_dec_digit = 4'hE;
      7'h0E: w_dec_digit = 4'hF;
      7'h7F: w_dec_blank = 1'b1;
      default: w_dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_ack_taken = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ACK) begin
          w_ack_taken = 1'b1;
          if (w_accept) w_load = 1'b1;
          else          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT  <= 4'h0;
      BLANK <= 1'b0;
      ERR   <= 1'b0;
    end else if (w_load) begin
      DOUT  <= w_dec_digit;
      BLANK <= w_dec_blank;
      ERR   <= w_dec_err;
    end
  end

  assign VALID = (r_state == HOLD);

`ifdef SEG7_READER_OVF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              OVF <= 1'b0;
    else if (w_drop)      OVF <= 1'b1;
    else if (w_ack_taken) OVF <= 1'b0;
  end
`else
  // Drops are silent in this build; the flag is intentionally unused
  logic w_unused;
  assign w_unused = w_drop ^ w_ack_taken;
`endif

endmodule
`default_nettype wire

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal range 2..255: consecutive sampled cycles a segment pattern must hold before it is accepted.
REQ-002 Port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port RST  in  1  asynchronous, active-high reset.
REQ-004 Port HEX  in  7  active-low segment bus, bit0=a ... bit6=g; asynchronous to CLK.
REQ-005 Port EN  in  1  capture enable.
REQ-006 Port ACK  in  1  consumer acknowledge of the current result.
REQ-007 Port DOUT  out  4  decoded hex digit; meaningful only while VALID=1.
REQ-008 Port BLANK  out  1  result is the blank pattern 7'h7F.
REQ-009 Port ERR  out  1  result is a pattern outside the code table and not blank.
REQ-010 Port VALID  out  1  result pending; held until acknowledged.
REQ-011 Port OVF  out  1  sticky drop flag; present only when SEG7_READER_OVF_EN is defined.

Function
REQ-012 HEX shall pass through a two-flop synchronizer; the second flop output is the sampled pattern S.
REQ-013 A stability counter shall restart at 1 on every edge where S differs from its previous value, otherwise increment, and saturate at STABLE_CYCLES.
REQ-014 An accept event shall fire on the edge where the counter reaches STABLE_CYCLES, only when S differs from the last accepted pattern L; L then takes S.
REQ-015 Each distinct stable pattern shall generate exactly one accept event; a pattern held indefinitely shall not repeat.
REQ-016 Code table, S to DOUT: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 58->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-017 S=7F shall produce BLANK=1, ERR=0, DOUT=0; any other pattern not in REQ-016 shall produce ERR=1, BLANK=0, DOUT=0.
REQ-018 Output FSM states: IDLE (VALID=0) and HOLD (VALID=1).
REQ-019 IDLE + accept event -> load DOUT/BLANK/ERR, enter HOLD on the same edge.
REQ-020 HOLD + ACK=1, no event -> IDLE on that edge; DOUT/BLANK/ERR keep their last values.
REQ-021 HOLD + ACK=1 + event on the same edge -> load new result and stay in HOLD.
REQ-022 HOLD + ACK=0 + event -> drop the new result, keep the pending one, and still update L.
REQ-023 ACK while IDLE shall be ignored.
REQ-024 Latency: a HEX value first sampled at edge k and held shall raise VALID after edge k+1+STABLE_CYCLES.
REQ-025 EN=0 shall hold the counter at 0, block accept events, and set L to "none" so the current pattern is reported again after EN rises; the pending result and FSM state are unaffected.

Reset
REQ-026 RST=1 shall immediately force: synchronizer flops and L to 7'h7F, counter 0, FSM IDLE, DOUT=0, BLANK=0, ERR=0, VALID=0, OVF=0.
REQ-027 A blank bus held through and after reset shall not generate an event.
REQ-028 Reset mid-count or mid-HOLD shall discard all progress and the pending result.

Configuration
REQ-029 Macro SEG7_READER_OVF_EN defined: OVF port present; OVF sets on any drop per REQ-022 and clears only on the edge where ACK=1 is taken in HOLD.
REQ-030 Macro SEG7_READER_OVF_EN undefined: no OVF port or logic; drops per REQ-022 are silent; all other behaviour identical.

Verification
REQ-031 Reset, HEX=7F held 50 cycles -> VALID stays 0.
REQ-032 STABLE_CYCLES=4, HEX=24 first sampled at edge 10 -> VALID=1, DOUT=2 after edge 15; ACK=1 at edge 18 -> VALID=0 after edge 18; no further event while HEX=24.
REQ-033 HEX toggles 30/19 every 2 cycles for 40 cycles, then holds 19 -> exactly one event, DOUT=4.
REQ-034 HEX=7F after a digit -> BLANK=1, ERR=0; HEX=7E -> ERR=1, BLANK=0, DOUT=0.
REQ-035 HEX=40 accepted, ACK held 0, then HEX=79 stable -> VALID stays 1, DOUT=0, OVF=1 (macro defined); ACK=1 -> VALID=0, OVF=0.
REQ-036 HEX=0E accepted and acked, EN=0 for 10 cycles then 1 -> second event, DOUT=F; RST pulsed mid-HOLD -> all outputs 0 at once.
